// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized serial line in, one word out through a
// single-entry valid/yumi register with parity, framing and overrun status.
module uart_rx #(
  parameter int clk_per_bit_p = 10416,
  parameter int data_bits_p   = 8,
  parameter int parity_bit_p  = 0,
  parameter int parity_odd_p  = 0,
  parameter int stop_bits_p   = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   rx_i,
  output logic                   rx_v_o,
  output logic [data_bits_p-1:0] rx_o,
  input  logic                   rx_yumi_i,
  output logic                   rx_parity_err_o,
  output logic                   rx_frame_err_o,
  output logic                   rx_overrun_o
);

  localparam int CW = $clog2(clk_per_bit_p);
  localparam logic [CW-1:0] half_last_lp = CW'(clk_per_bit_p / 2 - 1);
  localparam logic [CW-1:0] bit_last_lp  = CW'(clk_per_bit_p - 1);
  localparam logic [3:0]    data_last_lp = 4'(data_bits_p - 1);
  localparam logic [3:0]    stop_last_lp = 4'(stop_bits_p - 1);

  typedef enum logic [2:0] {
    e_reset, e_idle, e_start_bit, e_data_bits, e_parity_bit, e_stop_bit
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [data_bits_p-1:0] shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   rx_v_q, rx_v_d;
  logic [data_bits_p-1:0] rx_data_q, rx_data_d;
  logic                   rx_pe_q, rx_pe_d;
  logic                   rx_fe_q, rx_fe_d;
  logic                   rx_ovr_q, rx_ovr_d;
  logic                   rx_s;
  logic                   done;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d   = rx_i;
    sync2_d   = sync1_q;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    done      = 1'b0;
    case (state_q)
      e_reset: begin
        state_d   = e_idle;
        clk_cnt_d = '0;
      end
      e_idle: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        par_acc_d = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        if (!rx_s) state_d = e_start_bit;
      end
      e_start_bit: begin
        // A line that is high again at mid start bit was a glitch.
        if (clk_cnt_q == half_last_lp) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? e_idle : e_data_bits;
        end
      end
      e_data_bits: begin
        if (clk_cnt_q == bit_last_lp) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[data_bits_p-1:1]};
          par_acc_d = par_acc_q ^ rx_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == data_last_lp) begin
            bit_cnt_d = '0;
            state_d   = (parity_bit_p != 0) ? e_parity_bit : e_stop_bit;
          end
        end
      end
      e_parity_bit: begin
        if (clk_cnt_q == bit_last_lp) begin
          clk_cnt_d = '0;
          par_err_d = (par_acc_q ^ rx_s) != 1'(parity_odd_p);
          state_d   = e_stop_bit;
        end
      end
      e_stop_bit: begin
        // Deliver at mid last stop bit so the next start edge is not missed.
        if (clk_cnt_q == bit_last_lp) begin
          clk_cnt_d = '0;
          if (!rx_s) frm_err_d = 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == stop_last_lp) begin
            done    = 1'b1;
            state_d = e_idle;
          end
        end
      end
      default: state_d = e_reset;
    endcase
  end

  always_comb begin
    rx_v_d    = rx_v_q;
    rx_data_d = rx_data_q;
    rx_pe_d   = rx_pe_q;
    rx_fe_d   = rx_fe_q;
    rx_ovr_d  = 1'b0;
    if (rx_yumi_i) rx_v_d = 1'b0;
    if (done) begin
      if (!rx_v_q || rx_yumi_i) begin
        rx_v_d    = 1'b1;
        rx_data_d = shift_q;
        rx_pe_d   = par_err_q;
        rx_fe_d   = frm_err_d;
      end else begin
        rx_ovr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= e_reset;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      rx_v_q    <= 1'b0;
      rx_data_q <= '0;
      rx_pe_q   <= 1'b0;
      rx_fe_q   <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      rx_v_q    <= rx_v_d;
      rx_data_q <= rx_data_d;
      rx_pe_q   <= rx_pe_d;
      rx_fe_q   <= rx_fe_d;
      rx_ovr_q  <= rx_ovr_d;
    end
  end

  assign rx_v_o          = rx_v_q;
  assign rx_o            = rx_data_q;
  assign rx_parity_err_o = rx_pe_q;
  assign rx_frame_err_o  = rx_fe_q;
  assign rx_overrun_o    = rx_ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: four builds (8N1, 8E1, 8O1, 8N2) at 16 clocks
// per bit, each fed from its own frame generator.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx     [4];
  logic       yumi   [4];
  logic       rx_v   [4];
  logic [7:0] rx_o   [4];
  logic       pe     [4];
  logic       fe     [4];
  logic       ov     [4];
  int         ov_cnt [4];

  logic [15:0] fr_lv     [4];
  int          fr_nb     [4];
  int          fr_pos    [4];
  int          fr_cut    [4];
  int          fr_cutlen [4];
  logic        brk;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx #(.clk_per_bit_p(16), .data_bits_p(8), .parity_bit_p(0), .parity_odd_p(0), .stop_bits_p(1)) u_8n1 (
    .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx[0]), .rx_v_o(rx_v[0]), .rx_o(rx_o[0]),
    .rx_yumi_i(yumi[0]), .rx_parity_err_o(pe[0]), .rx_frame_err_o(fe[0]), .rx_overrun_o(ov[0]));
  uart_rx #(.clk_per_bit_p(16), .data_bits_p(8), .parity_bit_p(1), .parity_odd_p(0), .stop_bits_p(1)) u_8e1 (
    .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx[1]), .rx_v_o(rx_v[1]), .rx_o(rx_o[1]),
    .rx_yumi_i(yumi[1]), .rx_parity_err_o(pe[1]), .rx_frame_err_o(fe[1]), .rx_overrun_o(ov[1]));
  uart_rx #(.clk_per_bit_p(16), .data_bits_p(8), .parity_bit_p(1), .parity_odd_p(1), .stop_bits_p(1)) u_8o1 (
    .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx[2]), .rx_v_o(rx_v[2]), .rx_o(rx_o[2]),
    .rx_yumi_i(yumi[2]), .rx_parity_err_o(pe[2]), .rx_frame_err_o(fe[2]), .rx_overrun_o(ov[2]));
  uart_rx #(.clk_per_bit_p(16), .data_bits_p(8), .parity_bit_p(0), .parity_odd_p(0), .stop_bits_p(2)) u_8n2 (
    .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx[3]), .rx_v_o(rx_v[3]), .rx_o(rx_o[3]),
    .rx_yumi_i(yumi[3]), .rx_parity_err_o(pe[3]), .rx_frame_err_o(fe[3]), .rx_overrun_o(ov[3]));

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++)
      if (ov[d] === 1'b1) ov_cnt[d] <= ov_cnt[d] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One call = one clock; line levels change just after the rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < 4; d++) begin
        logic lvl;
        int   b;
        lvl = 1'b1;
        if (fr_pos[d] < fr_nb[d] * 16) begin
          b   = fr_pos[d] / 16;
          lvl = fr_lv[d][b];
          if (b == fr_cut[d] && (fr_pos[d] % 16) >= fr_cutlen[d]) lvl = 1'b1;
          fr_pos[d]++;
        end
        if (d == 0 && brk) lvl = 1'b0;
        rx[d] = lvl;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // par < 0: no parity bit. Bit 'cut' returns high after 'cutlen' cycles.
  task automatic start_frame(input int d, input logic [7:0] data, input int par,
                             input logic [1:0] stops, input int nstop,
                             input int cut, input int cutlen);
    logic [15:0] lv;
    int i;
    lv    = '1;
    lv[0] = 1'b0;
    i     = 1;
    for (int k = 0; k < 8; k++) begin lv[i] = data[k]; i++; end
    if (par >= 0) begin lv[i] = par[0]; i++; end
    for (int s = 0; s < nstop; s++) begin lv[i] = stops[s]; i++; end
    fr_lv[d] = lv; fr_nb[d] = i; fr_pos[d] = 0; fr_cut[d] = cut; fr_cutlen[d] = cutlen;
  endtask

  task automatic send(input int d, input logic [7:0] data, input int par,
                      input logic [1:0] stops, input int nstop);
    start_frame(d, data, par, stops, nstop, -1, 16);
    step(fr_nb[d] * 16);
  endtask

  task automatic take(input int d);
    yumi[d] = 1'b1;
    step(1);
    yumi[d] = 1'b0;
  endtask

  initial begin
    int ov0;
    reset_n = 1'b0;
    brk     = 1'b0;
    for (int d = 0; d < 4; d++) begin
      rx[d] = 1'b1; yumi[d] = 1'b0; ov_cnt[d] = 0;
      fr_nb[d] = 0; fr_pos[d] = 0; fr_cut[d] = -1; fr_cutlen[d] = 16; fr_lv[d] = '1;
    end
    step(3);
    chk("rst_v", rx_v[0], 0);
    chk("rst_o", rx_o[0], 0);
    chk("rst_pe", pe[0], 0);
    chk("rst_fe", fe[0], 0);
    chk("rst_ov", ov[0], 0);
    reset_n = 1'b1;
    step(5);

    // 8N1 0xA5: valid appears exactly 154 clocks after the first low sample
    start_frame(0, 8'hA5, -1, 2'b11, 1, -1, 16);
    step(154);
    chk("a5_early_v", rx_v[0], 0);
    step(1);
    chk("a5_v", rx_v[0], 1);
    chk("a5_o", rx_o[0], 8'hA5);
    chk("a5_pe", pe[0], 0);
    chk("a5_fe", fe[0], 0);
    take(0);
    chk("a5_consumed", rx_v[0], 0);
    step(24);

    // Even parity: 0x07 has three ones, so parity bit must be 1
    send(1, 8'h07, 0, 2'b11, 1);
    chk("e_bad_v", rx_v[1], 1);
    chk("e_bad_o", rx_o[1], 8'h07);
    chk("e_bad_pe", pe[1], 1);
    take(1); step(20);
    send(1, 8'h07, 1, 2'b11, 1);
    chk("e_ok_o", rx_o[1], 8'h07);
    chk("e_ok_pe", pe[1], 0);
    chk("e_ok_fe", fe[1], 0);
    take(1); step(20);
    send(2, 8'h07, 0, 2'b11, 1);
    chk("o_ok_v", rx_v[2], 1);
    chk("o_ok_pe", pe[2], 0);
    take(2); step(20);
    send(2, 8'h07, 1, 2'b11, 1);
    chk("o_bad_pe", pe[2], 1);
    take(2); step(20);

    // Low stop bit, released before the next mid-bit so no extra frame follows
    start_frame(0, 8'h3C, -1, 2'b10, 1, 9, 10);
    step(160);
    chk("fe1_v", rx_v[0], 1);
    chk("fe1_o", rx_o[0], 8'h3C);
    chk("fe1_fe", fe[0], 1);
    chk("fe1_pe", pe[0], 0);
    take(0); step(40);
    chk("fe1_no_extra", rx_v[0], 0);

    start_frame(3, 8'h96, -1, 2'b01, 2, 10, 10);
    step(176);
    chk("fe2_v", rx_v[3], 1);
    chk("fe2_o", rx_o[3], 8'h96);
    chk("fe2_fe", fe[3], 1);
    take(3); step(40);
    send(3, 8'h69, -1, 2'b11, 2);
    chk("n2_ok_o", rx_o[3], 8'h69);
    chk("n2_ok_fe", fe[3], 0);
    take(3); step(20);

    // 4-cycle glitch, then a real frame
    start_frame(0, 8'hFF, -1, 2'b11, 1, 0, 4);
    step(160);
    chk("glitch_v", rx_v[0], 0);
    send(0, 8'h55, -1, 2'b11, 1);
    chk("g55_v", rx_v[0], 1);
    chk("g55_o", rx_o[0], 8'h55);
    chk("g55_fe", fe[0], 0);
    take(0); step(20);

    // Back-to-back without consuming: second frame dropped with one overrun pulse
    ov0 = ov_cnt[0];
    send(0, 8'h11, -1, 2'b11, 1);
    send(0, 8'h22, -1, 2'b11, 1);
    chk("ovr_v", rx_v[0], 1);
    chk("ovr_o", rx_o[0], 8'h11);
    chk("ovr_pulses", ov_cnt[0] - ov0, 1);
    take(0);
    chk("ovr_consumed", rx_v[0], 0);
    step(20);

    // Yumi in the delivery cycle of the second frame
    ov0 = ov_cnt[0];
    send(0, 8'h11, -1, 2'b11, 1);
    start_frame(0, 8'h22, -1, 2'b11, 1, -1, 16);
    step(154);
    take(0);
    chk("swap_v", rx_v[0], 1);
    chk("swap_o", rx_o[0], 8'h22);
    chk("swap_no_ovr", ov_cnt[0] - ov0, 0);
    take(0);
    chk("swap_consumed", rx_v[0], 0);
    step(24);

    // Reset in the middle of 0xFF's data bits
    ov0 = ov_cnt[0];
    start_frame(0, 8'hFF, -1, 2'b11, 1, -1, 16);
    step(60);
    reset_n = 1'b0;
    step(3);
    chk("mrst_v", rx_v[0], 0);
    chk("mrst_o", rx_o[0], 0);
    chk("mrst_ov", ov[0], 0);
    reset_n = 1'b1;
    step(117);
    chk("mrst_no_deliv", rx_v[0], 0);
    send(0, 8'h81, -1, 2'b11, 1);
    chk("mrst_81_v", rx_v[0], 1);
    chk("mrst_81_o", rx_o[0], 8'h81);
    chk("mrst_no_ovr", ov_cnt[0] - ov0, 0);
    take(0); step(20);

    // Line held low: break frames keep arriving, receiver recovers afterwards
    ov0 = ov_cnt[0];
    brk = 1'b1;
    step(400);
    chk("brk_v", rx_v[0], 1);
    chk("brk_o", rx_o[0], 8'h00);
    chk("brk_fe", fe[0], 1);
    chk("brk_ovr", (ov_cnt[0] - ov0) > 0, 1);
    brk = 1'b0;
    step(200);
    take(0);
    step(200);
    chk("brk_recover", rx_v[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
